// File: rtl/ulpi_pkg.sv
// Shared constants and state encoding for the ULPI PHY-side responder.
// Covers TX CMD opcodes, RX CMD field layout and the fixed ID register addresses.
package ulpi_pkg;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_TX   = 2'b01;
  localparam logic [1:0] CMD_REGW = 2'b10;
  localparam logic [1:0] CMD_REGR = 2'b11;

  localparam int RXCMD_LS_LSB  = 0;
  localparam int RXCMD_EVT_LSB = 4;

  localparam logic [1:0] RXEVT_NONE   = 2'b00;
  localparam logic [1:0] RXEVT_ACTIVE = 2'b01;

  localparam logic [5:0] ADDR_VENDOR_LO  = 6'h00;
  localparam logic [5:0] ADDR_VENDOR_HI  = 6'h01;
  localparam logic [5:0] ADDR_PRODUCT_LO = 6'h02;
  localparam logic [5:0] ADDR_PRODUCT_HI = 6'h03;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REGW_CMD,
    ST_REGW_DATA,
    ST_REGW_STP,
    ST_REGR_CMD,
    ST_TURN1,
    ST_REGR_DATA,
    ST_TX_CMD,
    ST_TX_DATA,
    ST_RX_TURN,
    ST_RX_DATA,
    ST_RX_EOP,
    ST_RX_REL
  } state_t;

  function automatic logic [7:0] rx_cmd(input logic [1:0] evt, input logic [1:0] ls);
    rx_cmd = (8'(evt) << RXCMD_EVT_LSB) | (8'(ls) << RXCMD_LS_LSB);
  endfunction

endpackage

// File: rtl/ulpi_phy_regs.sv
// Register file served to the link: writable scratch registers above the
// read-only vendor/product ID bytes, with out-of-range addresses reading zero.
module ulpi_phy_regs #(
  parameter int          NREG       = 16,
  parameter logic [15:0] VENDOR_ID  = 16'h0424,
  parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
  input  logic       uclk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data
);
  import ulpi_pkg::*;

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [7:0] regs [NREG];
  logic       wr_ok;
  logic       rd_in_range;

  // ID bytes are decoded from parameters, so their storage slots never take writes
  assign wr_ok       = wr_en && (int'(wr_addr) < NREG) && (wr_addr > ADDR_PRODUCT_HI);
  assign rd_in_range = int'(rd_addr) < NREG;

  always_ff @(posedge uclk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
    end else if (wr_ok) begin
      regs[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if (rd_in_range) begin
      case (rd_addr)
        ADDR_VENDOR_LO:  rd_data = VENDOR_ID[7:0];
        ADDR_VENDOR_HI:  rd_data = VENDOR_ID[15:8];
        ADDR_PRODUCT_LO: rd_data = PRODUCT_ID[7:0];
        ADDR_PRODUCT_HI: rd_data = PRODUCT_ID[15:8];
        default:         rd_data = regs[rd_addr[AW-1:0]];
      endcase
    end
  end

endmodule

// File: rtl/ulpi_phy_resp.sv
// PHY-side ULPI responder: decodes link TX CMDs, serves the register file,
// forwards transmit bytes to the line model and turns the bus around for receive.
module ulpi_phy_resp #(
  parameter int          NREG       = 16,
  parameter logic [15:0] VENDOR_ID  = 16'h0424,
  parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
  input  logic       uclk,
  input  logic       reset,
  input  logic [7:0] udata_i,
  output logic [7:0] udata_o,
  output logic       udata_oe,
  input  logic       ustp,
  output logic       udir,
  output logic       unxt,
  input  logic [1:0] line_state,
  output logic       txp_dv,
  output logic [7:0] txp_data,
  output logic       txp_last,
  input  logic       txp_rdy,
  input  logic       rxp_dv,
  input  logic [7:0] rxp_data,
  input  logic       rxp_last,
  output logic       rxp_rdy
);
  import ulpi_pkg::*;

  state_t     state, state_d;
  logic [5:0] addr_q, addr_d;
  logic [3:0] pid_q, pid_d;
  logic       udir_d, unxt_d, oe_d, txp_dv_d, txp_last_d, wr_en;
  logic [7:0] udata_o_d, txp_data_d, rd_data;

  ulpi_phy_regs #(
    .NREG(NREG),
    .VENDOR_ID(VENDOR_ID),
    .PRODUCT_ID(PRODUCT_ID)
  ) u_regs (
    .uclk(uclk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(addr_q),
    .wr_data(udata_i),
    .rd_addr(addr_q),
    .rd_data(rd_data)
  );

  assign rxp_rdy = (state == ST_RX_DATA) && rxp_dv;

  always_ff @(posedge uclk) begin
    if (reset) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      pid_q    <= '0;
      udir     <= 1'b0;
      unxt     <= 1'b0;
      udata_oe <= 1'b0;
      udata_o  <= 8'h00;
      txp_dv   <= 1'b0;
      txp_data <= 8'h00;
      txp_last <= 1'b0;
    end else begin
      state    <= state_d;
      addr_q   <= addr_d;
      pid_q    <= pid_d;
      udir     <= udir_d;
      unxt     <= unxt_d;
      udata_oe <= oe_d;
      udata_o  <= udata_o_d;
      txp_dv   <= txp_dv_d;
      txp_data <= txp_data_d;
      txp_last <= txp_last_d;
    end
  end

  always_comb begin
    state_d    = state;
    addr_d     = addr_q;
    pid_d      = pid_q;
    udir_d     = udir;
    unxt_d     = unxt;
    oe_d       = udata_oe;
    udata_o_d  = udata_o;
    txp_dv_d   = 1'b0;
    txp_data_d = txp_data;
    txp_last_d = 1'b0;
    wr_en      = 1'b0;

    case (state)
      // A command on the bus always beats a pending receive packet
      ST_IDLE: begin
        if (udata_i != 8'h00) begin
          case (udata_i[7:6])
            CMD_TX: begin
              pid_d   = udata_i[3:0];
              unxt_d  = 1'b1;
              state_d = ST_TX_CMD;
            end
            CMD_REGW: begin
              addr_d  = udata_i[5:0];
              unxt_d  = 1'b1;
              state_d = ST_REGW_CMD;
            end
            CMD_REGR: begin
              addr_d  = udata_i[5:0];
              unxt_d  = 1'b1;
              state_d = ST_REGR_CMD;
            end
            CMD_IDLE: begin
            end
          endcase
        end else if (rxp_dv && !ustp) begin
          udir_d  = 1'b1;
          unxt_d  = 1'b1;
          state_d = ST_RX_TURN;
        end
      end
      ST_REGW_CMD: begin
        if (ustp) begin
          unxt_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REGW_DATA;
        end
      end
      ST_REGW_DATA: begin
        wr_en   = 1'b1;
        unxt_d  = 1'b0;
        state_d = ST_REGW_STP;
      end
      ST_REGW_STP: begin
        if (ustp) state_d = ST_IDLE;
      end
      ST_REGR_CMD: begin
        unxt_d  = 1'b0;
        udir_d  = 1'b1;
        state_d = ST_TURN1;
      end
      ST_TURN1: begin
        oe_d      = 1'b1;
        udata_o_d = rd_data;
        state_d   = ST_REGR_DATA;
      end
      ST_REGR_DATA: begin
        udir_d  = 1'b0;
        oe_d    = 1'b0;
        state_d = ST_IDLE;
      end
      ST_TX_CMD: begin
        txp_dv_d   = 1'b1;
        txp_data_d = {~pid_q, pid_q};
        unxt_d     = txp_rdy;
        state_d    = ST_TX_DATA;
      end
      // nxt mirrors the line model's readiness one cycle late, throttling the link
      ST_TX_DATA: begin
        if (ustp) begin
          txp_last_d = 1'b1;
          unxt_d     = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          if (unxt) begin
            txp_dv_d   = 1'b1;
            txp_data_d = udata_i;
          end
          unxt_d = txp_rdy;
        end
      end
      ST_RX_TURN: begin
        oe_d    = 1'b1;
        state_d = ST_RX_DATA;
      end
      ST_RX_DATA: begin
        if (rxp_dv) begin
          udata_o_d = rxp_data;
          unxt_d    = 1'b1;
          if (rxp_last) state_d = ST_RX_EOP;
        end else begin
          udata_o_d = rx_cmd(RXEVT_ACTIVE, line_state);
          unxt_d    = 1'b0;
        end
      end
      ST_RX_EOP: begin
        udata_o_d = rx_cmd(RXEVT_NONE, line_state);
        unxt_d    = 1'b0;
        state_d   = ST_RX_REL;
      end
      ST_RX_REL: begin
        udir_d  = 1'b0;
        oe_d    = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        udir_d  = 1'b0;
        unxt_d  = 1'b0;
        oe_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ulpi_phy_resp.sv
// Directed bench for ulpi_phy_resp: a vector table walks register, transmit and
// receive flows cycle by cycle; hand sequences cover bus contention and reset.
module tb_ulpi_phy_resp;

  logic       uclk = 1'b0;
  logic       reset;
  logic [7:0] udata_i;
  logic [7:0] udata_o;
  logic       udata_oe;
  logic       ustp;
  logic       udir;
  logic       unxt;
  logic [1:0] line_state;
  logic       txp_dv;
  logic [7:0] txp_data;
  logic       txp_last;
  logic       txp_rdy;
  logic       rxp_dv;
  logic [7:0] rxp_data;
  logic       rxp_last;
  logic       rxp_rdy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      nm;
    logic [7:0] d;
    logic       stp;
    logic       rdy;
    logic       rdv;
    logic [7:0] rdat;
    logic       rlast;
    logic       e_rdy;
    logic       e_udir;
    logic       e_unxt;
    logic       e_oe;
    logic       chk_do;
    logic [7:0] e_do;
    logic       e_tdv;
    logic [7:0] e_td;
    logic       e_tlast;
  } vec_t;

  vec_t vecs[$];

  ulpi_phy_resp dut (
    .uclk(uclk),
    .reset(reset),
    .udata_i(udata_i),
    .udata_o(udata_o),
    .udata_oe(udata_oe),
    .ustp(ustp),
    .udir(udir),
    .unxt(unxt),
    .line_state(line_state),
    .txp_dv(txp_dv),
    .txp_data(txp_data),
    .txp_last(txp_last),
    .txp_rdy(txp_rdy),
    .rxp_dv(rxp_dv),
    .rxp_data(rxp_data),
    .rxp_last(rxp_last),
    .rxp_rdy(rxp_rdy)
  );

  always #5 uclk = ~uclk;

  task automatic check_output(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  // The PHY must never drive the bus while the link owns it
  always @(negedge uclk) begin
    if (reset === 1'b0) begin
      total++;
      if (udata_oe === 1'b1 && udir !== 1'b1) begin
        bad++;
        $display("[TB] FAIL oe_without_dir: udata_oe=%b udir=%b", udata_oe, udir);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge uclk);
    #1;
  endtask

  task automatic add(input string nm, input logic [7:0] d, input logic stp, rdy, rdv,
                     input logic [7:0] rdat, input logic rlast,
                     input logic e_rdy, e_udir, e_unxt, e_oe, chk_do,
                     input logic [7:0] e_do, input logic e_tdv,
                     input logic [7:0] e_td, input logic e_tlast);
    vec_t v;
    v.nm = nm; v.d = d; v.stp = stp; v.rdy = rdy; v.rdv = rdv; v.rdat = rdat;
    v.rlast = rlast; v.e_rdy = e_rdy; v.e_udir = e_udir; v.e_unxt = e_unxt;
    v.e_oe = e_oe; v.chk_do = chk_do; v.e_do = e_do; v.e_tdv = e_tdv;
    v.e_td = e_td; v.e_tlast = e_tlast;
    vecs.push_back(v);
  endtask

  task automatic add_regw(input string tag, input logic [5:0] a, input logic [7:0] data);
    add({tag, ".e0"},  {2'b10, a}, 0, 1, 0, 0, 0,  0, 0, 1, 0,  0, 0,  0, 0, 0);
    add({tag, ".e1"},  {2'b10, a}, 0, 1, 0, 0, 0,  0, 0, 1, 0,  0, 0,  0, 0, 0);
    add({tag, ".e2"},  data,       0, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 0, 0);
    add({tag, ".stp"}, 8'h00,      1, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 0, 0);
  endtask

  task automatic add_regr(input string tag, input logic [5:0] a, input logic [7:0] exp);
    add({tag, ".e0"}, {2'b11, a}, 0, 1, 0, 0, 0,  0, 0, 1, 0,  0, 0,    0, 0, 0);
    add({tag, ".e1"}, {2'b11, a}, 0, 1, 0, 0, 0,  0, 1, 0, 0,  0, 0,    0, 0, 0);
    add({tag, ".e2"}, 8'h00,      0, 1, 0, 0, 0,  0, 1, 0, 1,  1, exp,  0, 0, 0);
    add({tag, ".e3"}, 8'h00,      0, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0,    0, 0, 0);
  endtask

  task automatic apply_stimulus(input vec_t v);
    udata_i  = v.d;
    ustp     = v.stp;
    txp_rdy  = v.rdy;
    rxp_dv   = v.rdv;
    rxp_data = v.rdat;
    rxp_last = v.rlast;
  endtask

  task automatic hand_read(input string tag, input logic [5:0] a, input logic [7:0] exp);
    udata_i = {2'b11, a};
    step();
    check_output({tag, ".nxt"}, 8'(unxt), 8'h01);
    step();
    check_output({tag, ".dir"}, 8'(udir), 8'h01);
    udata_i = 8'h00;
    step();
    check_output({tag, ".oe"}, 8'(udata_oe), 8'h01);
    check_output({tag, ".data"}, udata_o, exp);
    step();
    check_output({tag, ".release"}, 8'(udir), 8'h00);
  endtask

  initial begin
    reset      = 1'b1;
    udata_i    = 8'h00;
    ustp       = 1'b0;
    line_state = 2'b01;
    txp_rdy    = 1'b1;
    rxp_dv     = 1'b0;
    rxp_data   = 8'h00;
    rxp_last   = 1'b0;

    add_regw("regw_0a", 6'h0A, 8'h5C);
    add_regr("regr_0a", 6'h0A, 8'h5C);
    add_regr("regr_01", 6'h01, 8'h04);
    add_regw("regw_01", 6'h01, 8'hFF);
    add_regr("regr_01_again", 6'h01, 8'h04);
    add_regw("regw_11", 6'h11, 8'hFF);
    add_regr("regr_11", 6'h11, 8'h00);
    add("regw_abort.e0",  8'h85, 0, 1, 0, 0, 0,  0, 0, 1, 0,  0, 0,  0, 0, 0);
    add("regw_abort.stp", 8'h85, 1, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 0, 0);
    add_regr("regr_05", 6'h05, 8'h00);

    add("tx43.e0",     8'h43, 0, 1, 0, 0, 0,  0, 0, 1, 0,  0, 0,  0, 8'h00, 0);
    add("tx43.pid",    8'h43, 0, 1, 0, 0, 0,  0, 0, 1, 0,  0, 0,  1, 8'hC3, 0);
    add("tx43.b1",     8'h11, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,  1, 8'h11, 0);
    add("tx43.stall1", 8'h22, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 8'h00, 0);
    add("tx43.stall2", 8'h22, 0, 1, 0, 0, 0,  0, 0, 1, 0,  0, 0,  0, 8'h00, 0);
    add("tx43.b2",     8'h22, 0, 1, 0, 0, 0,  0, 0, 1, 0,  0, 0,  1, 8'h22, 0);
    add("tx43.stp",    8'h00, 1, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 8'h00, 1);
    add("tx43.idle",   8'h00, 0, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 8'h00, 0);
    add("tx44.e0",     8'h44, 0, 1, 0, 0, 0,  0, 0, 1, 0,  0, 0,  0, 8'h00, 0);
    add("tx44.pid",    8'h44, 0, 1, 0, 0, 0,  0, 0, 1, 0,  0, 0,  1, 8'hB4, 0);
    add("tx44.stp",    8'h00, 1, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 8'h00, 1);

    add("rx.start", 8'h00, 0, 1, 1, 8'hA1, 0,  0, 1, 1, 0,  0, 8'h00,  0, 0, 0);
    add("rx.turn",  8'h00, 0, 1, 1, 8'hA1, 0,  0, 1, 1, 1,  0, 8'h00,  0, 0, 0);
    add("rx.b1",    8'h00, 0, 1, 1, 8'hA1, 0,  1, 1, 1, 1,  1, 8'hA1,  0, 0, 0);
    add("rx.b2",    8'h00, 0, 1, 1, 8'hB2, 0,  1, 1, 1, 1,  1, 8'hB2,  0, 0, 0);
    add("rx.gap",   8'h00, 0, 1, 0, 8'h00, 0,  0, 1, 0, 1,  1, 8'h11,  0, 0, 0);
    add("rx.b3",    8'h00, 0, 1, 1, 8'hC3, 1,  1, 1, 1, 1,  1, 8'hC3,  0, 0, 0);
    add("rx.eop",   8'h00, 0, 1, 0, 8'h00, 0,  0, 1, 0, 1,  1, 8'h01,  0, 0, 0);
    add("rx.rel",   8'h00, 0, 1, 0, 8'h00, 0,  0, 0, 0, 0,  0, 8'h00,  0, 0, 0);

    step();
    step();
    check_output("reset.udir", 8'(udir), 8'h00);
    check_output("reset.unxt", 8'(unxt), 8'h00);
    check_output("reset.oe", 8'(udata_oe), 8'h00);
    check_output("reset.udata_o", udata_o, 8'h00);
    check_output("reset.txp_dv", 8'(txp_dv), 8'h00);
    check_output("reset.txp_last", 8'(txp_last), 8'h00);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      #1;
      check_output({vecs[i].nm, ".rxp_rdy"}, 8'(rxp_rdy), 8'(vecs[i].e_rdy));
      step();
      check_output({vecs[i].nm, ".udir"}, 8'(udir), 8'(vecs[i].e_udir));
      check_output({vecs[i].nm, ".unxt"}, 8'(unxt), 8'(vecs[i].e_unxt));
      check_output({vecs[i].nm, ".oe"}, 8'(udata_oe), 8'(vecs[i].e_oe));
      check_output({vecs[i].nm, ".txp_dv"}, 8'(txp_dv), 8'(vecs[i].e_tdv));
      check_output({vecs[i].nm, ".txp_last"}, 8'(txp_last), 8'(vecs[i].e_tlast));
      if (vecs[i].chk_do) check_output({vecs[i].nm, ".udata_o"}, udata_o, vecs[i].e_do);
      if (vecs[i].e_tdv) check_output({vecs[i].nm, ".txp_data"}, txp_data, vecs[i].e_td);
    end

    // Receive request while the link issues a read: the read runs to completion first
    udata_i  = 8'hC2;
    ustp     = 1'b0;
    txp_rdy  = 1'b1;
    rxp_dv   = 1'b1;
    rxp_data = 8'h5A;
    rxp_last = 1'b1;
    step();
    check_output("contend.cmd_nxt", 8'(unxt), 8'h01);
    check_output("contend.cmd_dir", 8'(udir), 8'h00);
    step();
    check_output("contend.turn_dir", 8'(udir), 8'h01);
    check_output("contend.turn_oe", 8'(udata_oe), 8'h00);
    udata_i = 8'h00;
    #1;
    check_output("contend.no_consume", 8'(rxp_rdy), 8'h00);
    step();
    check_output("contend.read_data", udata_o, 8'h09);
    step();
    check_output("contend.read_release", 8'(udir), 8'h00);
    step();
    check_output("contend.rx_dir", 8'(udir), 8'h01);
    check_output("contend.rx_nxt", 8'(unxt), 8'h01);
    step();
    check_output("contend.rx_oe", 8'(udata_oe), 8'h01);
    step();
    check_output("contend.rx_byte", udata_o, 8'h5A);
    rxp_dv   = 1'b0;
    rxp_last = 1'b0;
    step();
    check_output("contend.rx_eop", udata_o, 8'h01);
    step();
    check_output("contend.rx_release", 8'(udir), 8'h00);

    // Reset in the middle of a receive packet drops the bus and restores defaults
    rxp_dv   = 1'b1;
    rxp_data = 8'h77;
    step();
    step();
    step();
    check_output("rst_rx.byte", udata_o, 8'h77);
    reset = 1'b1;
    step();
    check_output("rst_rx.udir", 8'(udir), 8'h00);
    check_output("rst_rx.oe", 8'(udata_oe), 8'h00);
    check_output("rst_rx.unxt", 8'(unxt), 8'h00);
    reset  = 1'b0;
    rxp_dv = 1'b0;
    step();
    hand_read("id0", 6'h00, 8'h24);
    hand_read("id1", 6'h01, 8'h04);
    hand_read("id2", 6'h02, 8'h09);
    hand_read("id3", 6'h03, 8'h00);
    hand_read("scratch_cleared", 6'h0A, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
